cpu_clock_controller: RTL

Run/halt/single-step controller for the CPU core clock. It runs on the free-running CLK and produces a one-cycle clock-enable pulse, cpu_ce, that gates every architectural state update in the core. It has a programmable rate divider, a debug command port with a valid/ready handshake, and a halt-on-breakpoint input. It sits between the clock source and the core's control unit.

---
 rtl/cpu_clock_controller.sv | 96 +++++++++
 1 files changed

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: run/halt/single-step controller producing the core clock enable,
// with programmable rate divider, debug command port and breakpoint halt.
module cpu_clock_controller #(
  parameter int DIV_WIDTH  = 16,
  parameter int STEP_WIDTH = 16,
  parameter int RESET_DIV  = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  input  logic        breakpoint,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic        step_done,
  output logic        bp_hit,
  output logic [31:0] ce_count
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} state_e;
  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_reg_q, div_reg_d, div_cnt_q, div_cnt_d;
  logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d, step_n;
  logic                  step_done_q, step_done_d, bp_hit_q, bp_hit_d;
  logic [31:0]           ce_count_q, ce_count_d;
  logic                  accept;
  assign cpu_ce    = (state_q == RUN || state_q == STEP) && div_cnt_q == div_reg_q;
  assign cmd_ready = state_q != STEP && !breakpoint;
  assign accept    = cmd_valid && cmd_ready;
  assign step_n    = cmd_arg[STEP_WIDTH-1:0];
  assign state     = state_q;
  assign step_done = step_done_q;
  assign bp_hit    = bp_hit_q;
  assign ce_count  = ce_count_q;
  always_comb begin
    state_d     = state_q;
    div_reg_d   = div_reg_q;
    div_cnt_d   = (state_q == HALT || cpu_ce) ? '0 : div_cnt_q + DIV_WIDTH'(1);
    step_cnt_d  = (state_q == STEP && cpu_ce) ? step_cnt_q - STEP_WIDTH'(1) : step_cnt_q;
    step_done_d = state_q == STEP && cpu_ce && step_cnt_q == STEP_WIDTH'(1);
    bp_hit_d    = breakpoint && state_q != HALT;
    ce_count_d  = ce_count_q + 32'(cpu_ce);
    // a breakpoint also blocks accept, so it never collides with a command
    if (step_done_d || bp_hit_d) begin
      state_d   = HALT;
      div_cnt_d = '0;
    end else if (accept) begin
      case (cmd_op)
        OP_HALT: begin
          state_d   = HALT;
          div_cnt_d = '0;
        end
        OP_RUN: begin
          state_d   = RUN;
          div_cnt_d = '0;
        end
        OP_STEP: begin
          if (step_n != '0) begin
            state_d    = STEP;
            step_cnt_d = step_n;
            div_cnt_d  = '0;
          end else begin
            step_done_d = 1'b1;
          end
        end
        default: begin
          div_reg_d = cmd_arg[DIV_WIDTH-1:0];
          div_cnt_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= HALT;
      div_reg_q   <= DIV_WIDTH'(RESET_DIV);
      div_cnt_q   <= '0;
      step_cnt_q  <= '0;
      step_done_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      ce_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_reg_q   <= div_reg_d;
      div_cnt_q   <= div_cnt_d;
      step_cnt_q  <= step_cnt_d;
      step_done_q <= step_done_d;
      bp_hit_q    <= bp_hit_d;
      ce_count_q  <= ce_count_d;
    end
  end
endmodule
